// File: rtl/display_pkg.sv
// Shared definitions for the display scheduler: FSM states, source indices
// and the width of one displayed number.
package display_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHOW0 = 3'd1,
        SHOW1 = 3'd2,
        ALARM = 3'd3,
        OFF   = 3'd4
    } disp_state_e;

    localparam int SRC_TEMP  = 0;
    localparam int SRC_SET   = 1;
    localparam int SRC_ALARM = 2;
    localparam int NUM_SRC   = 3;
    localparam int DIGIT_W   = 16;

endpackage

// File: rtl/scan_divider.sv
// Scan clock generator: free-running count 0..SCAN_DIV-1, a 50% duty scan
// clock and a one-cycle tick in the last cycle of each period.
module scan_divider #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic disp_clk,
    output logic scan_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SCAN_DIV / 2);

    logic [CNT_W-1:0] count_q, count_d;
    logic             disp_clk_q, disp_clk_d;

    // disp_clk is registered so it reads 0 out of reset and stays glitch-free.
    always_comb begin
        count_d    = (count_q == CNT_LAST) ? '0 : count_q + CNT_W'(1);
        disp_clk_d = (count_q < CNT_HALF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            disp_clk_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            disp_clk_q <= disp_clk_d;
        end
    end

    assign disp_clk  = disp_clk_q;
    assign scan_tick = (count_q == CNT_LAST);

endmodule

// File: rtl/disp_scheduler.sv
// Arbitrates the 4-digit display between temperature, setpoint and alarm.
// Every decision and every output update happens on the scan-tick edge.
module disp_scheduler
    import display_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int DWELL_TICKS = 2000,
    parameter int BLINK_TICKS = 250
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       disp_on,
    input  logic [NUM_SRC-1:0]         req,
    input  logic [NUM_SRC*DIGIT_W-1:0] data,
    output logic [NUM_SRC-1:0]         grant,
    output logic [DIGIT_W-1:0]         disp_num,
    output logic                       disp_blank,
    output logic                       disp_clk,
    output logic                       scan_tick
);

    localparam int DW_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam int BL_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_TICKS - 1);
    localparam logic [BL_W-1:0] BLINK_LAST = BL_W'(BLINK_TICKS - 1);

    disp_state_e          state_q, state_d, next_state;
    logic [DIGIT_W-1:0]   shadow_q [NUM_SRC];
    logic [DIGIT_W-1:0]   shadow_d [NUM_SRC];
    logic [DW_W-1:0]      dwell_q, dwell_d;
    logic [BL_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                 blink_phase_q, blink_phase_d;
    logic                 resume_q, resume_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic [DIGIT_W-1:0]   disp_num_q, disp_num_d;
    logic                 disp_blank_q, disp_blank_d;
    logic                 in_show;

    scan_divider #(.SCAN_DIV(SCAN_DIV)) u_scan_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .disp_clk  (disp_clk),
        .scan_tick (scan_tick)
    );

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            shadow_d[i] = req[i] ? data[DIGIT_W*i +: DIGIT_W] : shadow_q[i];
        end
    end

    assign in_show = (state_q == SHOW0) || (state_q == SHOW1);

    always_comb begin
        next_state = IDLE;
        if (!disp_on) begin
            next_state = OFF;
        end else if (req[SRC_ALARM]) begin
            next_state = ALARM;
        end else if (req[SRC_TEMP] && req[SRC_SET]) begin
            // Rotation: keep the current source until its dwell expires;
            // otherwise pick up where the last normal source left off.
            if (in_show) begin
                if (dwell_q == DWELL_LAST) begin
                    next_state = (state_q == SHOW0) ? SHOW1 : SHOW0;
                end else begin
                    next_state = state_q;
                end
            end else begin
                next_state = resume_q ? SHOW1 : SHOW0;
            end
        end else if (req[SRC_TEMP]) begin
            next_state = SHOW0;
        end else if (req[SRC_SET]) begin
            next_state = SHOW1;
        end
    end

    always_comb begin
        state_d       = state_q;
        dwell_d       = dwell_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        resume_d      = resume_q;
        grant_d       = grant_q;
        disp_num_d    = disp_num_q;
        disp_blank_d  = disp_blank_q;
        if (scan_tick) begin
            state_d = next_state;
            if (next_state != state_q) begin
                dwell_d       = '0;
                blink_cnt_d   = '0;
                blink_phase_d = 1'b0;
            end else if (in_show) begin
                // Saturate so a long single-source stretch cannot wrap.
                dwell_d = (dwell_q == DWELL_LAST) ? dwell_q : dwell_q + DW_W'(1);
            end else if (state_q == ALARM) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BL_W'(1);
                end
            end
            case (next_state)
                SHOW0: begin
                    disp_num_d   = shadow_q[SRC_TEMP];
                    disp_blank_d = 1'b0;
                    grant_d      = NUM_SRC'(1 << SRC_TEMP);
                    resume_d     = 1'b0;
                end
                SHOW1: begin
                    disp_num_d   = shadow_q[SRC_SET];
                    disp_blank_d = 1'b0;
                    grant_d      = NUM_SRC'(1 << SRC_SET);
                    resume_d     = 1'b1;
                end
                ALARM: begin
                    disp_num_d   = shadow_q[SRC_ALARM];
                    disp_blank_d = blink_phase_d;
                    grant_d      = NUM_SRC'(1 << SRC_ALARM);
                end
                default: begin
                    disp_blank_d = 1'b1;
                    grant_d      = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            dwell_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            resume_q      <= 1'b0;
            grant_q       <= '0;
            disp_num_q    <= '0;
            disp_blank_q  <= 1'b1;
            for (int i = 0; i < NUM_SRC; i++) shadow_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            dwell_q       <= dwell_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            resume_q      <= resume_d;
            grant_q       <= grant_d;
            disp_num_q    <= disp_num_d;
            disp_blank_q  <= disp_blank_d;
            for (int i = 0; i < NUM_SRC; i++) shadow_q[i] <= shadow_d[i];
        end
    end

    assign grant      = grant_q;
    assign disp_num   = disp_num_q;
    assign disp_blank = disp_blank_q;

endmodule

// File: tb/tb_disp_scheduler.sv
// Bench for disp_scheduler: directed scenarios plus random traffic, every
// cycle compared against a behavioural model of the display rules.
module tb_disp_scheduler;

    localparam int DIV = 4;
    localparam int DW  = 3;
    localparam int BT  = 2;

    localparam int M_IDLE  = 0;
    localparam int M_SHOW0 = 1;
    localparam int M_SHOW1 = 2;
    localparam int M_ALARM = 3;
    localparam int M_OFF   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_on;
    logic [2:0]  req;
    logic [47:0] data;
    logic [2:0]  grant;
    logic [15:0] disp_num;
    logic        disp_blank;
    logic        disp_clk;
    logic        scan_tick;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    int m_cnt, m_clk, m_mode, m_dwell, m_bticks, m_phase, m_resume;
    int m_sh [3];
    int m_num, m_blank, m_grant;

    disp_scheduler #(.SCAN_DIV(DIV), .DWELL_TICKS(DW), .BLINK_TICKS(BT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_on    (disp_on),
        .req        (req),
        .data       (data),
        .grant      (grant),
        .disp_num   (disp_num),
        .disp_blank (disp_blank),
        .disp_clk   (disp_clk),
        .scan_tick  (scan_tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_clk = 0; m_mode = M_IDLE; m_dwell = 0;
        m_bticks = 0; m_phase = 0; m_resume = 0;
        for (int i = 0; i < 3; i++) m_sh[i] = 0;
        m_num = 0; m_blank = 1; m_grant = 0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        int nxt;
        bit tick;
        tick = (m_cnt == DIV - 1);
        if (tick) begin
            if (!disp_on) nxt = M_OFF;
            else if (req[2]) nxt = M_ALARM;
            else if (req[0] && req[1]) begin
                if (m_mode == M_SHOW0 || m_mode == M_SHOW1)
                    nxt = (m_dwell >= DW - 1) ? (M_SHOW0 + M_SHOW1 - m_mode) : m_mode;
                else
                    nxt = (m_resume == 1) ? M_SHOW1 : M_SHOW0;
            end
            else if (req[0]) nxt = M_SHOW0;
            else if (req[1]) nxt = M_SHOW1;
            else nxt = M_IDLE;

            if (nxt != m_mode) begin
                m_dwell = 0; m_bticks = 0; m_phase = 0;
            end else if (nxt == M_SHOW0 || nxt == M_SHOW1) begin
                m_dwell++;
            end else if (nxt == M_ALARM) begin
                m_bticks++;
                if (m_bticks == BT) begin
                    m_bticks = 0;
                    m_phase  = 1 - m_phase;
                end
            end
            m_mode = nxt;
            if (nxt == M_SHOW0 || nxt == M_SHOW1) begin
                m_resume = nxt - M_SHOW0;
                m_num    = m_sh[m_resume];
                m_blank  = 0;
                m_grant  = 1 << m_resume;
            end else if (nxt == M_ALARM) begin
                m_num = m_sh[2]; m_blank = m_phase; m_grant = 4;
            end else begin
                m_blank = 1; m_grant = 0;
            end
        end
        for (int i = 0; i < 3; i++)
            if (req[i]) m_sh[i] = int'(data[16*i +: 16]);
        m_clk = (m_cnt < DIV / 2) ? 1 : 0;
        m_cnt = tick ? 0 : m_cnt + 1;
    endtask

    task automatic check_all();
        check_eq("grant",      32'(grant),      32'(m_grant));
        check_eq("disp_num",   32'(disp_num),   32'(m_num));
        check_eq("disp_blank", 32'(disp_blank), 32'(m_blank));
        check_eq("disp_clk",   32'(disp_clk),   32'(m_clk));
        check_eq("scan_tick",  32'(scan_tick),  (m_cnt == DIV - 1) ? 32'd1 : 32'd0);
    endtask

    // Called at a falling edge with inputs already set; returns at the next one.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            model_edge();
            @(posedge clk);
            #1;
            check_all();
            @(negedge clk);
        end
    endtask

    task automatic set_data(input int d0, input int d1, input int d2);
        data = {16'(d2), 16'(d1), 16'(d0)};
    endtask

    initial begin
        rst_n = 1'b0; disp_on = 1'b1; req = 3'b000; data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        check_eq("rst_blank", 32'(disp_blank), 32'd1);
        check_eq("rst_num",   32'(disp_num),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // idle after reset, tick cadence
        step(8);

        // single source
        set_data(1234, 0, 0); req = 3'b001;
        step(12);
        check_eq("single_num", 32'(disp_num), 32'd1234);
        check_eq("single_grant", 32'(grant), 32'd1);
        req = 3'b000;
        step(8);
        check_eq("idle_blank", 32'(disp_blank), 32'd1);

        // rotation
        set_data(215, 250, 0); req = 3'b011;
        step(DIV * 14);

        // alarm preempts while setpoint is shown
        for (int k = 0; k < 40 && m_mode != M_SHOW1; k++) step(1);
        check_eq("reach_show1", 32'(grant), 32'd2);
        set_data(215, 250, 9001); req = 3'b111;
        step(DIV * 6);
        check_eq("alarm_num", 32'(disp_num), 32'd9001);
        check_eq("alarm_grant", 32'(grant), 32'd4);
        req = 3'b011;
        step(DIV * 5);

        // global blank, then back to alarm
        req = 3'b111; disp_on = 1'b0;
        step(DIV * 2);
        check_eq("off_grant", 32'(grant), 32'd0);
        disp_on = 1'b1;
        step(DIV * 3);

        // mid-period data change
        set_data(100, 0, 0); req = 3'b001;
        step(DIV * 2);
        for (int k = 0; k < DIV && m_cnt != 1; k++) step(1);
        set_data(200, 0, 0);
        step(DIV * 2);
        check_eq("mid_num", 32'(disp_num), 32'd200);

        // asynchronous reset mid-operation
        set_data(4321, 777, 55); req = 3'b011;
        step(DIV * 3 + 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(DIV * 4);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) disp_on = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 7) == 0)
                set_data($urandom_range(0, 9999), $urandom_range(0, 9999), $urandom_range(0, 9999));
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
